// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-controller-side signals of mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;

    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          we0;
    logic          we1;
    logic [SW-1:0] size0;
    logic [SW-1:0] size1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [SW-1:0] mem_size;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          gnt;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, size0, size1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_read, mem_write,
               mem_size, busy, gnt
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, size0, size1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_read, mem_write,
               mem_size, busy, gnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing the memory controller between fetch (port 0)
// and load/store (port 1); one transaction at a time, registered read data and ack.
module mem_arbiter #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 3;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [SW-1:0]     size_q, size_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     rdata0_q, rdata0_d;
    logic [DW-1:0]     rdata1_q, rdata1_d;
    logic              win_c;
    logic              rd_done_c;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        win_c     = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
        rd_done_c = (cnt_q == CNT_W'(READ_LAT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req0 || bus.req1) state_d = ACCESS;
            ACCESS:  if (we_q || rd_done_c)    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Hold registers are loaded only at grant, so mem_* ignore requester inputs afterwards.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        size_d     = size_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d      = win_c;
                    last_gnt_d = win_c;
                    cnt_d      = '0;
                    addr_d     = win_c ? bus.addr1  : bus.addr0;
                    wdata_d    = win_c ? bus.wdata1 : bus.wdata0;
                    we_d       = win_c ? bus.we1    : bus.we0;
                    size_d     = win_c ? bus.size1  : bus.size0;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (rd_done_c) begin
                        if (gnt_q) rdata1_d = bus.mem_rdata;
                        else       rdata0_d = bus.mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            size_q     <= size_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Strobes and acks decode registered state only; async reset clears them at once.
    always_comb begin
        bus.mem_read  = (state_q == ACCESS) && !we_q;
        bus.mem_write = (state_q == ACCESS) &&  we_q;
        bus.ack0      = (state_q == RESP) && !gnt_q;
        bus.ack1      = (state_q == RESP) &&  gnt_q;
        bus.busy      = (state_q != IDLE);
        bus.gnt       = gnt_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_size  = size_q;
        bus.rdata0    = rdata0_q;
        bus.rdata1    = rdata1_q;
    end
endmodule
